// File: rtl/multi_cycle_ctrl.sv
// Stage sequencer for a five-stage multi-cycle CPU: one stage active at a time,
// bus-register load enables, single-step pause, per-stage watchdog and counters.
module multi_cycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             step,
  input  logic             IF_over,
  input  logic             ID_over,
  input  logic             EXE_over,
  input  logic             MEM_over,
  input  logic             WB_over,
  output logic             IF_valid,
  output logic             ID_valid,
  output logic             EXE_valid,
  output logic             MEM_valid,
  output logic             WB_valid,
  output logic             IF_ID_en,
  output logic             ID_EXE_en,
  output logic             EXE_MEM_en,
  output logic             MEM_WB_en,
  output logic             next_fetch,
  output logic             hang,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IF    = 3'd1,
    S_ID    = 3'd2,
    S_EXE   = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_PAUSE = 3'd6,
    S_HANG  = 3'd7
  } state_e;

  // The watchdog only ever needs to count 0 .. TIMEOUT-1.
  localparam bit          WD_ON     = (TIMEOUT != 0);
  localparam int unsigned WD_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WD_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LAST_I);

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              hang_q, hang_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  inst_cnt_q, inst_cnt_d;

  logic              stage_over;
  logic              if_id_en_c, id_exe_en_c, exe_mem_en_c, mem_wb_en_c;
  logic              next_fetch_c;
  logic              run;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    wd_d         = '0;
    hang_d       = hang_q;
    cycle_cnt_d  = cycle_cnt_q + 1'b1;
    inst_cnt_d   = inst_cnt_q;
    if_id_en_c   = 1'b0;
    id_exe_en_c  = 1'b0;
    exe_mem_en_c = 1'b0;
    mem_wb_en_c  = 1'b0;
    next_fetch_c = 1'b0;

    // Only the active stage's done flag is looked at; the others are ignored.
    case (state_q)
      S_IF:    stage_over = IF_over;
      S_ID:    stage_over = ID_over;
      S_EXE:   stage_over = EXE_over;
      S_MEM:   stage_over = MEM_over;
      S_WB:    stage_over = WB_over;
      default: stage_over = 1'b0;
    endcase

    case (state_q)
      S_IDLE: state_d = S_IF;

      S_IF, S_ID, S_EXE, S_MEM, S_WB: begin
        if (stage_over) begin
          case (state_q)
            S_IF: begin
              state_d    = S_ID;
              if_id_en_c = 1'b1;
            end
            S_ID: begin
              state_d     = S_EXE;
              id_exe_en_c = 1'b1;
            end
            S_EXE: begin
              state_d      = S_MEM;
              exe_mem_en_c = 1'b1;
            end
            S_MEM: begin
              state_d     = S_WB;
              mem_wb_en_c = 1'b1;
            end
            S_WB: begin
              state_d      = step_en ? S_PAUSE : S_IF;
              next_fetch_c = 1'b1;
              inst_cnt_d   = inst_cnt_q + 1'b1;
            end
            default: ;
          endcase
        end else if (WD_ON && (wd_q == WD_LAST)) begin
          // A done flag arriving on the last allowed cycle is taken above.
          state_d = S_HANG;
          hang_d  = 1'b1;
        end else if (WD_ON) begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_PAUSE: begin
        if (step || !step_en) state_d = S_IF;
      end

      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      hang_q      <= 1'b0;
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      hang_q      <= hang_d;
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
    end
  end

  // Reset masks every strobe in the cycle it is asserted, even mid-stage.
  assign run = ~reset;

  assign IF_valid   = run && (state_q == S_IF);
  assign ID_valid   = run && (state_q == S_ID);
  assign EXE_valid  = run && (state_q == S_EXE);
  assign MEM_valid  = run && (state_q == S_MEM);
  assign WB_valid   = run && (state_q == S_WB);

  assign IF_ID_en   = run && if_id_en_c;
  assign ID_EXE_en  = run && id_exe_en_c;
  assign EXE_MEM_en = run && exe_mem_en_c;
  assign MEM_WB_en  = run && mem_wb_en_c;
  assign next_fetch = run && next_fetch_c;

  assign hang      = hang_q;
  assign state     = state_q;
  assign cycle_cnt = cycle_cnt_q;
  assign inst_cnt  = inst_cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed scenarios plus random done/step/reset
// traffic, checked every cycle against a stage-level reference model.
module tb_multi_cycle_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;
  localparam int CMOD    = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset, step_en, step;
  logic [4:0]       over_vec;
  logic [4:0]       over_mask;
  logic             IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
  logic             IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en;
  logic             next_fetch, hang;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt, inst_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: stage number 0..7, watchdog age, counters.
  int m_state, m_wd, m_cyc, m_inst;
  bit m_hang;

  // Observations gathered by tick() for scenario-level checks.
  int n_id_valid, n_mem_valid, n_exe_mem_en, n_mem_wb_en, n_any_valid;
  logic last_nf;
  logic [2:0] last_state;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .step_en   (step_en),
    .step      (step),
    .IF_over   (over_vec[0]),
    .ID_over   (over_vec[1]),
    .EXE_over  (over_vec[2]),
    .MEM_over  (over_vec[3]),
    .WB_over   (over_vec[4]),
    .IF_valid  (IF_valid),
    .ID_valid  (ID_valid),
    .EXE_valid (EXE_valid),
    .MEM_valid (MEM_valid),
    .WB_valid  (WB_valid),
    .IF_ID_en  (IF_ID_en),
    .ID_EXE_en (ID_EXE_en),
    .EXE_MEM_en(EXE_MEM_en),
    .MEM_WB_en (MEM_WB_en),
    .next_fetch(next_fetch),
    .hang      (hang),
    .state     (state),
    .cycle_cnt (cycle_cnt),
    .inst_cnt  (inst_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] onehot(input int s);
    return (s >= 1 && s <= 5) ? 5'(1 << (s - 1)) : 5'd0;
  endfunction

  task automatic model_advance(input bit cur_over);
    if (reset) begin
      m_state = 0; m_wd = 0; m_hang = 0; m_cyc = 0; m_inst = 0;
    end else begin
      m_cyc = (m_cyc + 1) % CMOD;
      if (m_state == 0) begin
        m_state = 1;
      end else if (m_state >= 1 && m_state <= 5) begin
        if (cur_over) begin
          m_wd = 0;
          if (m_state == 5) begin
            m_inst  = (m_inst + 1) % CMOD;
            m_state = step_en ? 6 : 1;
          end else begin
            m_state = m_state + 1;
          end
        end else if (m_wd == TIMEOUT - 1) begin
          m_state = 7;
          m_hang  = 1;
        end else begin
          m_wd = m_wd + 1;
        end
      end else if (m_state == 6) begin
        if (step || !step_en) m_state = 1;
      end
    end
  endtask

  // One clock: inputs are already set; check outputs, take the edge, advance the model.
  task automatic tick();
    logic [4:0] ev;
    logic [3:0] ee;
    bit         cur_over;
    #1;
    cur_over = |(over_vec & onehot(m_state));
    ev = reset ? 5'd0 : onehot(m_state);
    ee = (!reset && cur_over) ? ev[3:0] : 4'd0;
    check("state",      32'(state), 32'(m_state));
    check("valid",      32'({WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid}), 32'(ev));
    check("bus_en",     32'({MEM_WB_en, EXE_MEM_en, ID_EXE_en, IF_ID_en}), 32'(ee));
    check("next_fetch", 32'(next_fetch), 32'(!reset && cur_over && m_state == 5));
    check("hang",       32'(hang), 32'(m_hang));
    check("cycle_cnt",  32'(cycle_cnt), 32'(m_cyc));
    check("inst_cnt",   32'(inst_cnt), 32'(m_inst));
    n_id_valid   += int'(ID_valid);
    n_mem_valid  += int'(MEM_valid);
    n_exe_mem_en += int'(EXE_MEM_en);
    n_mem_wb_en  += int'(MEM_WB_en);
    n_any_valid  += int'(IF_valid | ID_valid | EXE_valid | MEM_valid | WB_valid);
    last_nf    = next_fetch;
    last_state = state;
    @(posedge clk);
    model_advance(cur_over);
    @(negedge clk);
  endtask

  task automatic tick_auto();
    over_vec = onehot(m_state) & over_mask;
    tick();
  endtask

  task automatic clear_counts();
    n_id_valid = 0; n_mem_valid = 0; n_exe_mem_en = 0; n_mem_wb_en = 0; n_any_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    over_vec = 5'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_until(input string tag, input int target, input int max_cycles);
    for (int i = 0; i < max_cycles && m_state != target; i++) tick_auto();
    check(tag, 32'(state), 32'(target));
  endtask

  initial begin
    reset = 1'b1; step_en = 1'b0; step = 1'b0;
    over_vec = 5'd0; over_mask = 5'h1f;
    m_state = 0; m_wd = 0; m_hang = 0; m_cyc = 0; m_inst = 0;
    clear_counts();
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // Full-speed run: over tied to valid for 20 cycles.
    for (int k = 1; k <= 20; k++) begin
      tick_auto();
      check("seq_state", 32'(last_state), (k == 1) ? 32'd0 : 32'(((k - 2) % 5) + 1));
      check("seq_nf",    32'(last_nf), 32'(k == 6 || k == 11 || k == 16));
    end
    check("seq_inst_cnt",  32'(inst_cnt), 32'd3);
    check("seq_cycle_cnt", 32'(cycle_cnt), 32'd20);

    // MEM done held off 3 cycles; it arrives exactly on the last watchdog cycle.
    run_until("reach_if_mem", 1, 10);
    clear_counts();
    begin
      int mem_wait;
      mem_wait = 0;
      for (int i = 0; i < 8; i++) begin
        over_vec = onehot(m_state);
        if (m_state == 4 && mem_wait < 3) begin
          over_vec = 5'd0;
          mem_wait++;
        end
        tick();
      end
    end
    check("mem_valid_cycles", 32'(n_mem_valid), 32'd4);
    check("exe_mem_en_count", 32'(n_exe_mem_en), 32'd1);
    check("mem_wb_en_count",  32'(n_mem_wb_en), 32'd1);
    check("mem_no_hang",      32'(hang), 32'd0);

    // Single-step mode.
    do_reset();
    step_en = 1'b1;
    run_until("reach_pause", 6, 12);
    check("pause_inst_cnt", 32'(inst_cnt), 32'd1);
    clear_counts();
    for (int i = 0; i < 10; i++) tick_auto();
    check("pause_held",   32'(state), 32'd6);
    check("pause_valids", 32'(n_any_valid), 32'd0);
    step = 1'b1;
    tick_auto();
    step = 1'b0;
    check("step_to_if", 32'(state), 32'd1);
    run_until("reach_pause2", 6, 12);
    check("pause2_inst_cnt", 32'(inst_cnt), 32'd2);
    step_en = 1'b0;
    tick_auto();
    check("step_en_drop_exit", 32'(state), 32'd1);

    // Watchdog: ID never finishes.
    do_reset();
    over_mask = 5'b11101;
    clear_counts();
    for (int i = 0; i < 12; i++) tick_auto();
    check("wd_id_cycles",  32'(n_id_valid), 32'd4);
    check("wd_hang_state", 32'(state), 32'd7);
    check("wd_hang_flag",  32'(hang), 32'd1);
    check("wd_cycle_cnt",  32'(cycle_cnt), 32'd12);
    over_mask = 5'h1f;
    do_reset();
    check("wd_reset_state", 32'(state), 32'd0);
    check("wd_reset_hang",  32'(hang), 32'd0);
    check("wd_reset_cnt",   32'(cycle_cnt), 32'd0);

    // Reset landing in EXE while EXE is done.
    run_until("reach_exe", 3, 10);
    over_vec = onehot(3);
    reset = 1'b1;
    #1;
    check("rst_exe_en", 32'(EXE_MEM_en), 32'd0);
    tick();
    reset = 1'b0;
    check("rst_exe_state", 32'(state), 32'd0);
    run_until("rst_restart_if", 1, 3);
    check("rst_restart_inst", 32'(inst_cnt), 32'd0);

    // Stray done flags from other stages while in ID and EXE.
    run_until("reach_id_stray", 2, 10);
    for (int i = 0; i < 2; i++) begin
      over_vec = 5'b10001;
      tick();
      check("stray_id_hold", 32'(state), 32'd2);
    end
    run_until("reach_exe_stray", 3, 4);
    for (int i = 0; i < 2; i++) begin
      over_vec = 5'b10011;
      tick();
      check("stray_exe_hold", 32'(state), 32'd3);
      check("stray_exe_nf",   32'(last_nf), 32'd0);
    end
    check("stray_inst_cnt", 32'(inst_cnt), 32'd0);

    // Long full-speed run so both counters wrap.
    do_reset();
    for (int i = 0; i < 1400; i++) tick_auto();
    check("wrap_inst_cnt", 32'(inst_cnt), 32'(((1400 - 1) / 5) % CMOD));

    // Random done/step/reset traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 5; b++) over_vec[b] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) step_en = ~step_en;
      step  = ($urandom_range(0, 7) == 0);
      reset = (m_state == 7 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 1999) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Stage sequencer for the five-stage multi-cycle CPU (IF, ID, EXE, MEM, WB). Exactly one stage is active at a time.
- Drives each stage's *_valid and advances on that stage's *_over.
- Pulses load enables for the inter-stage bus registers (IF_ID_bus_r … MEM_WB_bus_r) and next_fetch for the PC.
- Provides single-step mode, a per-stage watchdog and cycle/instruction counters for the display path.

Parameters:
- TIMEOUT, 16, max cycles a stage may hold valid without over; 0 disables the watchdog.
- CNT_W, 32, width of cycle_cnt and inst_cnt.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- step_en  input  1  1 = single-step mode: pause after each WB.
- step  input  1  releases one instruction while paused; level-sampled.
- IF_over  input  1  IF stage done.
- ID_over  input  1  ID stage done.
- EXE_over  input  1  EXE stage done.
- MEM_over  input  1  MEM stage done.
- WB_over  input  1  WB stage done.
- IF_valid  output  1  IF stage active.
- ID_valid  output  1  ID stage active.
- EXE_valid  output  1  EXE stage active.
- MEM_valid  output  1  MEM stage active.
- WB_valid  output  1  WB stage active.
- IF_ID_en  output  1  load IF->ID bus register this edge.
- ID_EXE_en  output  1  load ID->EXE bus register this edge.
- EXE_MEM_en  output  1  load EXE->MEM bus register this edge.
- MEM_WB_en  output  1  load MEM->WB bus register this edge.
- next_fetch  output  1  PC advance pulse, one cycle.
- hang  output  1  sticky watchdog error flag.
- state  output  3  current state code, for display.
- cycle_cnt  output  CNT_W  cycles since reset.
- inst_cnt  output  CNT_W  retired instructions.

Behaviour:
- State codes: IDLE=0, IF=1, ID=2, EXE=3, MEM=4, WB=5, PAUSE=6, HANG=7. State is registered.
- Reset (sync, any state, including mid-stage):
  - state=IDLE, cycle_cnt=0, inst_cnt=0, hang=0, watchdog counter=0.
  - All valids, *_en and next_fetch = 0 in the reset cycle.
- IDLE -> IF unconditionally on the next cycle.
- *_valid = (state == that stage). Purely decoded from the state register; no combinational path from any *_over.
- In stage X, X's *_over is sampled combinationally. A single-cycle stage (over = valid) therefore occupies exactly 1 cycle.
- *_over of any stage other than the current one is ignored.
- Transitions on over: IF->ID, ID->EXE, EXE->MEM, MEM->WB. In that same cycle the matching *_en is 1 (IF_ID_en in IF, etc.), so the bus register captures at that edge.
- WB with WB_over:
  - next_fetch=1 for that cycle; inst_cnt increments at the edge.
  - Next state = PAUSE if step_en=1, else IF.
- PAUSE: stays until step=1, then -> IF.
  - step_en dropping to 0 while in PAUSE also exits to IF.
  - step held high re-enters PAUSE after each WB; no edge detection.
- Fastest throughput: 5 cycles per instruction. First IF_valid appears in cycle 2 after reset is released.
- Watchdog (TIMEOUT>0):
  - wd counter clears on every stage entry and increments each cycle the stage's over=0.
  - If it reaches TIMEOUT-1 and over is still 0: next state HANG, hang<=1.
  - HANG: all valids/en = 0; left only by reset.
  - Over arriving in the same cycle the count reaches TIMEOUT-1: over wins, normal advance.
  - Not active in IDLE or PAUSE.
- cycle_cnt increments every non-reset cycle in all states, including PAUSE and HANG.
- Both counters wrap modulo 2^CNT_W silently.
- At most one *_en or next_fetch is high in any cycle.

Test Plan:
- Reset released, all over tied to valid, step_en=0, 20 cycles:
  - state sequence 0,1,2,3,4,5,1,…
  - each *_en high exactly in its stage cycle; next_fetch at cycles 6,11,16.
  - inst_cnt=3, cycle_cnt=20.
- MEM_over delayed 3 cycles (TIMEOUT=16):
  - MEM_valid high for 4 cycles; EXE_MEM_en only once.
  - MEM_WB_en only in the cycle MEM_over=1; no hang.
- step_en=1, step=0:
  - after first WB, state=6 held 10 cycles, all valids 0, inst_cnt=1.
  - pulse step one cycle -> IF next, second instruction completes, back to PAUSE, inst_cnt=2.
- TIMEOUT=4, ID_over held 0:
  - ID_valid high 4 cycles, then state=7, hang=1, all valids 0; cycle_cnt keeps counting.
  - reset -> state=0, hang=0, counters 0.
- Reset asserted while in EXE with EXE_over=1:
  - EXE_MEM_en=0 in that cycle, state=0 next.
  - Restart from IF with inst_cnt=0.
- Stray WB_over/IF_over pulses while in ID or EXE: no state change, no next_fetch, inst_cnt unchanged.
